// File: rtl/fsm_seqn_sequencer_if.sv
// Bus bundle for the ring sequencer: requests in, state and event flags out.
// The bench or parent drives through master; the sequencer sits on slave.
interface fsm_seqn_sequencer_if #(
    parameter int NSTATES = 4,
    parameter int DW      = 16,
    parameter int TMO_W   = 8
);
    localparam int SW = (NSTATES > 1) ? $clog2(NSTATES) : 1;

    logic [NSTATES-1:0] t;
    logic               dir;
    logic               hold;
    logic               ld;
    logic [SW-1:0]      ld_st;
    logic [TMO_W-1:0]   tmo_val;
    logic [SW-1:0]      st;
    logic [NSTATES-1:0] st_oh;
    logic               st_entry;
    logic               wrap;
    logic               ld_err;
    logic [DW-1:0]      dwell;
    logic               tmo;

    modport master (
        output t, dir, hold, ld, ld_st, tmo_val,
        input  st, st_oh, st_entry, wrap, ld_err, dwell, tmo
    );

    modport slave (
        input  t, dir, hold, ld, ld_st, tmo_val,
        output st, st_oh, st_entry, wrap, ld_err, dwell, tmo
    );
endinterface

// File: rtl/fsm_seqn_sequencer.sv
// N-state ring sequencer with load, hold, dwell count and wrap/entry pulses.
// Define FSM_SEQN_TIMEOUT_EN to build the per-state forced-advance timeout.
module fsm_seqn_sequencer #(
    parameter int NSTATES = 4,
    parameter int DW      = 16,
    parameter int TMO_W   = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    fsm_seqn_sequencer_if.slave bus
);
    localparam int SW = (NSTATES > 1) ? $clog2(NSTATES) : 1;
    localparam logic [SW-1:0] LAST = SW'(NSTATES - 1);
    localparam logic [SW:0]   NS_W = (SW + 1)'(NSTATES);

    typedef enum logic [2:0] {
        K_STAY,
        K_LOAD,
        K_STEP,
        K_TMO
    } kind_e;

    logic [SW-1:0]      st_q, st_d;
    logic [NSTATES-1:0] st_oh_q, st_oh_d;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic               st_entry_q, st_entry_d;
    logic               wrap_q, wrap_d;
    logic               ld_err_q, ld_err_d;
    logic               tmo_q, tmo_d;

    kind_e         kind;
    logic          ld_ok;
    logic          bad_st;
    logic          t_cur;
    logic          tmo_hit;
    logic [SW-1:0] st_fwd;
    logic [SW-1:0] st_bwd;
    logic [SW-1:0] st_step;
    logic          wrap_step;

    assign ld_ok  = bus.ld && ({1'b0, bus.ld_st} < NS_W);
    assign bad_st = {1'b0, st_q} >= NS_W;
    assign t_cur  = |(bus.t & st_oh_q);

`ifdef FSM_SEQN_TIMEOUT_EN
    localparam int CW = (DW > TMO_W) ? DW : TMO_W;
    logic [CW-1:0] dwell_x;
    logic [CW-1:0] tv_x;

    assign dwell_x = CW'(dwell_q);
    assign tv_x    = CW'(bus.tmo_val);
    // A state lasts tmo_val cycles: fire when dwell reaches tmo_val-1.
    assign tmo_hit = (bus.tmo_val != '0)
                  && (dwell_x >= tv_x - CW'(1));
`else
    logic unused_tmo_val;

    assign unused_tmo_val = ^bus.tmo_val;
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        st_fwd  = (st_q == LAST) ? '0 : st_q + SW'(1);
        st_bwd  = (st_q == '0) ? LAST : st_q - SW'(1);
        st_step = bus.dir ? st_bwd : st_fwd;
        // With two states both directions coincide; 1->0 is the wrap.
        if (NSTATES == 2)
            wrap_step = (st_q == LAST);
        else if (bus.dir)
            wrap_step = (st_q == '0);
        else
            wrap_step = (st_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q       <= '0;
            st_oh_q    <= NSTATES'(1);
            dwell_q    <= '0;
            st_entry_q <= 1'b0;
            wrap_q     <= 1'b0;
            ld_err_q   <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            st_q       <= st_d;
            st_oh_q    <= st_oh_d;
            dwell_q    <= dwell_d;
            st_entry_q <= st_entry_d;
            wrap_q     <= wrap_d;
            ld_err_q   <= ld_err_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        st_d = st_q;
        kind = K_STAY;
        if (ld_ok) begin
            st_d = bus.ld_st;
            kind = K_LOAD;
        end else if (bad_st) begin
            st_d = '0;
            kind = K_LOAD;
        end else if (bus.hold) begin
            st_d = st_q;
            kind = K_STAY;
        end else if (t_cur) begin
            st_d = st_step;
            kind = K_STEP;
        end else if (tmo_hit) begin
            st_d = st_step;
            kind = K_TMO;
        end
    end

    always_comb begin
        st_oh_d    = NSTATES'(1) << st_d;
        st_entry_d = (kind != K_STAY);
        wrap_d     = ((kind == K_STEP) || (kind == K_TMO))
                  && wrap_step;
        tmo_d      = (kind == K_TMO);
        ld_err_d   = bus.ld && !ld_ok;
        if (kind != K_STAY)
            dwell_d = '0;
        else if (dwell_q == '1)
            dwell_d = dwell_q;
        else
            dwell_d = dwell_q + DW'(1);
    end

    assign bus.st       = st_q;
    assign bus.st_oh    = st_oh_q;
    assign bus.dwell    = dwell_q;
    assign bus.st_entry = st_entry_q;
    assign bus.wrap     = wrap_q;
    assign bus.ld_err   = ld_err_q;
    assign bus.tmo      = tmo_q;
endmodule

// File: tb/tb_fsm_seqn_sequencer.sv
// Directed bench: a 5-state ring (4-bit dwell) and a 2-state ring.
// Timeout expectations switch on FSM_SEQN_TIMEOUT_EN.
module tb_fsm_seqn_sequencer;
    logic clk;
    logic rst_n;
    int   nerr;
    int   nchk;

    fsm_seqn_sequencer_if #(.NSTATES(5), .DW(4), .TMO_W(8)) a_if ();
    fsm_seqn_sequencer_if #(.NSTATES(2), .DW(8), .TMO_W(4)) b_if ();

    fsm_seqn_sequencer #(.NSTATES(5), .DW(4), .TMO_W(8)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    fsm_seqn_sequencer #(.NSTATES(2), .DW(8), .TMO_W(4)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        nerr = 0;
        nchk = 0;
        rst_n = 1'b0;
        a_if.t = '0;
        a_if.dir = 1'b0;
        a_if.hold = 1'b0;
        a_if.ld = 1'b0;
        a_if.ld_st = '0;
        a_if.tmo_val = '0;
        b_if.t = '0;
        b_if.dir = 1'b0;
        b_if.hold = 1'b0;
        b_if.ld = 1'b0;
        b_if.ld_st = '0;
        b_if.tmo_val = '0;

        step();
        step();
        chk("rst_st", a_if.st, 0);
        chk("rst_oh", a_if.st_oh, 5'b00001);
        chk("rst_dwell", a_if.dwell, 0);
        chk("rst_entry", a_if.st_entry, 0);
        chk("rst_wrap", a_if.wrap, 0);
        chk("rst_lderr", a_if.ld_err, 0);
        chk("rst_tmo", a_if.tmo, 0);
        chk("b_rst_st", b_if.st, 0);
        rst_n = 1'b1;

        b_if.t = 2'b01;
        b_if.dir = 1'b1;
        step();
        chk("b_0to1_st", b_if.st, 1);
        chk("b_0to1_wrap", b_if.wrap, 0);
        b_if.t = 2'b10;
        step();
        chk("b_1to0b_st", b_if.st, 0);
        chk("b_1to0b_wrap", b_if.wrap, 1);
        b_if.t = 2'b01;
        b_if.dir = 1'b0;
        step();
        chk("b_0to1f_wrap", b_if.wrap, 0);
        b_if.t = 2'b10;
        step();
        chk("b_1to0f_st", b_if.st, 0);
        chk("b_1to0f_wrap", b_if.wrap, 1);
        b_if.t = 2'b00;
        step();
        chk("b_idle_wrap", b_if.wrap, 0);
        chk("a_idle_dwell", a_if.dwell, 5);
        chk("a_idle_st", a_if.st, 0);

        a_if.t = 5'b00001;
        step();
        chk("adv_st", a_if.st, 1);
        chk("adv_oh", a_if.st_oh, 5'b00010);
        chk("adv_entry", a_if.st_entry, 1);
        chk("adv_dwell", a_if.dwell, 0);
        a_if.t = '0;
        step();
        chk("dw1_entry", a_if.st_entry, 0);
        chk("dw1", a_if.dwell, 1);
        step();
        chk("dw2", a_if.dwell, 2);
        step();
        chk("dw3", a_if.dwell, 3);
        a_if.t = 5'b00001;
        step();
        chk("foreign_t_st", a_if.st, 1);
        chk("foreign_t_dw", a_if.dwell, 4);

        a_if.t = 5'b00010;
        step();
        chk("f_st2", a_if.st, 2);
        chk("f_st2_wrap", a_if.wrap, 0);
        a_if.t = 5'b00100;
        step();
        chk("f_st3", a_if.st, 3);
        a_if.t = 5'b01000;
        step();
        chk("f_st4", a_if.st, 4);
        chk("f_st4_oh", a_if.st_oh, 5'b10000);
        a_if.t = 5'b10000;
        step();
        chk("f_wrap_st", a_if.st, 0);
        chk("f_wrap", a_if.wrap, 1);
        chk("f_wrap_entry", a_if.st_entry, 1);
        a_if.t = '0;
        step();
        chk("f_wrap_clr", a_if.wrap, 0);

        a_if.dir = 1'b1;
        a_if.t = 5'b00001;
        step();
        chk("b_wrap_st", a_if.st, 4);
        chk("b_wrap", a_if.wrap, 1);
        a_if.t = 5'b10000;
        step();
        chk("b_st3", a_if.st, 3);
        chk("b_st3_wrap", a_if.wrap, 0);
        a_if.t = '0;
        step();
        a_if.dir = 1'b0;
        a_if.t = 5'b01000;
        step();
        chk("dir_idle_st", a_if.st, 4);
        a_if.t = '0;

        a_if.ld = 1'b1;
        a_if.ld_st = 3'd6;
        step();
        chk("lderr", a_if.ld_err, 1);
        chk("lderr_st", a_if.st, 4);
        chk("lderr_entry", a_if.st_entry, 0);
        chk("lderr_dw", a_if.dwell, 1);
        a_if.ld_st = 3'd3;
        a_if.hold = 1'b1;
        a_if.t = 5'b10000;
        step();
        chk("ld_st", a_if.st, 3);
        chk("ld_entry", a_if.st_entry, 1);
        chk("ld_wrap", a_if.wrap, 0);
        chk("ld_lderr", a_if.ld_err, 0);
        chk("ld_dw", a_if.dwell, 0);
        a_if.hold = 1'b0;
        a_if.ld_st = 3'd7;
        a_if.t = 5'b01000;
        step();
        chk("lderr_adv_err", a_if.ld_err, 1);
        chk("lderr_adv_st", a_if.st, 4);
        chk("lderr_adv_ent", a_if.st_entry, 1);
        a_if.ld_st = 3'd4;
        a_if.t = '0;
        step();
        chk("reent_st", a_if.st, 4);
        chk("reent_entry", a_if.st_entry, 1);
        chk("reent_dw", a_if.dwell, 0);
        a_if.ld = 1'b0;

        a_if.hold = 1'b1;
        a_if.t = 5'b10000;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("hold_st", a_if.st, 4);
            chk("hold_dw", a_if.dwell, i);
        end
        a_if.hold = 1'b0;
        step();
        chk("unhold_st", a_if.st, 0);
        chk("unhold_wrap", a_if.wrap, 1);
        a_if.t = '0;
        repeat (20) step();
        chk("sat_dw", a_if.dwell, 15);
        chk("sat_st", a_if.st, 0);

        a_if.ld = 1'b1;
        a_if.ld_st = 3'd2;
        step();
        chk("pre_rst_st", a_if.st, 2);
        a_if.ld_st = 3'd3;
        a_if.t = 5'b00100;
        rst_n = 1'b0;
        step();
        chk("mrst_st", a_if.st, 0);
        chk("mrst_oh", a_if.st_oh, 5'b00001);
        chk("mrst_dw", a_if.dwell, 0);
        chk("mrst_entry", a_if.st_entry, 0);
        chk("mrst_wrap", a_if.wrap, 0);
        chk("mrst_lderr", a_if.ld_err, 0);
        a_if.ld = 1'b0;
        a_if.t = '0;
        rst_n = 1'b1;

        a_if.tmo_val = 8'd3;
        step();
        step();
        chk("tmo_e2_st", a_if.st, 0);
        step();
`ifdef FSM_SEQN_TIMEOUT_EN
        chk("tmo_e3_st", a_if.st, 1);
        chk("tmo_e3_tmo", a_if.tmo, 1);
        chk("tmo_e3_ent", a_if.st_entry, 1);
`else
        chk("tmo_e3_st", a_if.st, 0);
        chk("tmo_e3_tmo", a_if.tmo, 0);
`endif
        step();
        chk("tmo_e4_tmo", a_if.tmo, 0);
        step();
        step();
`ifdef FSM_SEQN_TIMEOUT_EN
        chk("tmo_e6_st", a_if.st, 2);
        chk("tmo_e6_tmo", a_if.tmo, 1);
`else
        chk("tmo_e6_st", a_if.st, 0);
`endif
        a_if.tmo_val = '0;
        repeat (8) step();
`ifdef FSM_SEQN_TIMEOUT_EN
        chk("tmo_off_st", a_if.st, 2);
`else
        chk("tmo_off_st", a_if.st, 0);
`endif
        chk("tmo_off_tmo", a_if.tmo, 0);

        a_if.tmo_val = 8'd1;
        a_if.t = a_if.st_oh;
        step();
`ifdef FSM_SEQN_TIMEOUT_EN
        chk("t_beats_tmo_st", a_if.st, 3);
`else
        chk("t_beats_tmo_st", a_if.st, 1);
`endif
        chk("t_beats_tmo", a_if.tmo, 0);
        a_if.t = '0;
        step();
`ifdef FSM_SEQN_TIMEOUT_EN
        chk("tmo1_st", a_if.st, 4);
        chk("tmo1_tmo", a_if.tmo, 1);
`else
        chk("tmo1_st", a_if.st, 1);
        chk("tmo1_tmo", a_if.tmo, 0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/fsm_seqn_sequencer.md
Name: fsm_seqn_sequencer

Overview:
Parametrised N-state ring sequencer for control-path state tracking.
- Each state i waits for its own advance request t[i]; the ring can run forward or backward.
- Supports direct state load, hold, per-state dwell counting, and entry/wrap event pulses.
- Optional per-state timeout forces an advance when the request never arrives.

Parameters:
NSTATES, 4, number of ring states; legal 2..256; SW = max(1, clog2(NSTATES)) is derived, not overridable
DW, 16, dwell counter width; legal 1..32
TMO_W, 8, timeout value width; legal 1..32

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous reset, active low
t  in  NSTATES  t[i] = advance request, honoured only while in state i
dir  in  1  0 = forward (i -> i+1 mod NSTATES), 1 = backward (i -> i-1 mod NSTATES)
hold  in  1  blocks advances and timeouts; dwell keeps counting
ld  in  1  load request
ld_st  in  SW  target state for ld
tmo_val  in  TMO_W  timeout in cycles per state; 0 = disabled
st  out  SW  current state, binary
st_oh  out  NSTATES  current state, one-hot; always equals 1 << st
st_entry  out  1  high in the first cycle of every new state occupancy
wrap  out  1  high in the first cycle after a ring wrap
ld_err  out  1  one-cycle pulse when ld is rejected
dwell  out  DW  cycles spent in current state
tmo  out  1  high in the first cycle of a timeout-forced state

Behaviour:
- All outputs are registered. A request sampled at edge k is visible after edge k; there is no combinational input-to-output path.
- Reset (rst_n = 0 at an edge) has top priority and aborts anything in progress:
  - st = 0, st_oh = 1, dwell = 0.
  - st_entry = 0, wrap = 0, ld_err = 0, tmo = 0.
- Priority order at each edge: reset > ld > hold > t[st] advance > timeout.
- ld with ld_st < NSTATES:
  - st = ld_st, dwell = 0, st_entry = 1.
  - Applies even if ld_st equals st (re-entry) and even under hold.
  - wrap = 0, tmo = 0.
- ld with ld_st >= NSTATES:
  - Load is ignored and ld_err = 1 for one cycle.
  - The remaining priority chain (hold/advance/timeout) then evaluates normally in that same cycle.
- Advance (no ld, hold = 0, t[st] = 1):
  - Move one step in the direction given by dir; dwell = 0, st_entry = 1.
  - Bits t[j] for j != st are ignored.
- wrap = 1 when an advance or timeout moves NSTATES-1 -> 0 (forward) or 0 -> NSTATES-1 (backward). A load never sets wrap.
- No transition: st holds, st_entry = 0, wrap = 0, tmo = 0, dwell = dwell + 1, saturating at 2^DW - 1.
- Non-power-of-two NSTATES: unused encodings are unreachable. If one is ever present, the next state is 0 with st_entry = 1 (defensive recovery).
- dir is sampled at the transition edge only. Changing dir while idle has no effect.
- NSTATES = 2: forward and backward steps are identical; wrap is set on every 1 -> 0 transition regardless of dir.

Optional Feature:
Macro: FSM_SEQN_TIMEOUT_EN
- Defined:
  - Forced advance (direction per dir) when no ld, hold = 0, t[st] = 0, tmo_val != 0, and dwell >= tmo_val - 1, so a state lasts exactly tmo_val cycles.
  - On a forced advance: tmo = 1 together with st_entry = 1; wrap follows the normal rule.
  - If t[st] = 1 in the same cycle, it counts as a normal advance and tmo = 0.
  - Comparison is done at max(DW, TMO_W) bits. With DW < TMO_W, a tmo_val beyond the saturated dwell never fires.
- Undefined:
  - tmo_val is ignored and tmo is tied to 0; no timeout logic is synthesised.
  - Port list is unchanged.

Test Plan:
- NSTATES = 4, reset then t = 4'b0001 for 1 cycle -> st 0 -> 1, st_oh = 4'b0010, st_entry pulses 1 cycle, dwell = 0 then counts 1, 2, 3.
- NSTATES = 5, dir = 0, step through all states with t[st] = 1 -> after 4 -> 0 wrap = 1; then dir = 1 from 0 -> st = 4, wrap = 1.
- NSTATES = 5, ld = 1, ld_st = 6 -> ld_err = 1, st unchanged. Then ld_st = 3 with hold = 1 and t[st] = 1 -> st = 3, st_entry = 1, wrap = 0.
- hold = 1 with t[st] = 1 for 10 cycles -> st unchanged, dwell advances 0..9. Release hold with t[st] still 1 -> st steps on the next edge.
- FSM_SEQN_TIMEOUT_EN defined, tmo_val = 3, t = 0 -> state changes every 3 cycles with tmo = 1 on each entry. tmo_val = 0 -> no movement.
- Mid-sequence rst_n = 0 for 1 cycle while ld = 1 and t[st] = 1 -> st = 0, dwell = 0, all pulses 0 on the next cycle.
